// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module : counter_pkg
// Desc   : Shared sequence-select and direction encodings for the up/down counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam logic [1:0] SEQ_ALL  = 2'b00;
    localparam logic [1:0] SEQ_ODD  = 2'b01;
    localparam logic [1:0] SEQ_EVEN = 2'b10;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_next_calc.sv
//------------------------------------------------------------------------------
// Module : counter_next_calc
// Desc   : Combinational parity-forced base, stepped value and terminal compare.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic             dir,
    input  logic [1:0]       seq_sel,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_val,
    output logic [WIDTH-1:0] load_fixed,
    output logic             at_terminal
);

    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_top_even = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             w_odd;
    logic             w_even;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_terminal;

    // seq_sel = 11 decodes as neither odd nor even, i.e. all-values mode
    assign w_odd  = (seq_sel == SEQ_ODD);
    assign w_even = (seq_sel == SEQ_EVEN);

    always_comb begin
        w_base     = cur_val;
        load_fixed = load_val;
        if (w_odd) begin
            w_base[0]     = 1'b1;
            load_fixed[0] = 1'b1;
        end else if (w_even) begin
            w_base[0]     = 1'b0;
            load_fixed[0] = 1'b0;
        end

        w_step = (w_odd || w_even) ? WIDTH'(2) : WIDTH'(1);

        if (dir == DIR_UP) begin
            next_val   = w_base + w_step;
            w_terminal = w_even ? c_top_even : c_all_ones;
        end else begin
            next_val   = w_base - w_step;
            w_terminal = w_odd ? c_one : c_zero;
        end
    end

    // Compare against the raw count so tc follows count, dir and seq_sel directly
    assign at_terminal = (cur_val == w_terminal);

endmodule

`default_nettype wire

// File: rtl/odd_even_updown_counter.sv
//------------------------------------------------------------------------------
// Module : odd_even_updown_counter
// Desc   : Configurable all/odd/even up/down counter with load, wrap or saturate.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module odd_even_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       seq_sel,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_fixed;
    logic             w_tc;

    counter_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .cur_val     (r_count),
        .dir         (dir),
        .seq_sel     (seq_sel),
        .load_val    (load_val),
        .next_val    (w_next),
        .load_fixed  (w_load_fixed),
        .at_terminal (w_tc)
    );

    // Priority: reset, load, enabled step (saturate holds at terminal)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '1;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_count   <= w_load_fixed;
            r_wrapped <= 1'b0;
        end else if (en) begin
            if (w_tc && sat_mode) begin
                r_wrapped <= 1'b0;
            end else begin
                r_count   <= w_next;
                r_wrapped <= w_tc;
            end
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign count   = r_count;
    assign wrapped = r_wrapped;
    assign tc      = w_tc;

endmodule

`default_nettype wire

// File: tb/tb_odd_even_updown_counter.sv
//------------------------------------------------------------------------------
// Module : tb_odd_even_updown_counter
// Desc   : Scoreboard bench for odd_even_updown_counter at WIDTH = 3.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_odd_even_updown_counter;

    localparam int WIDTH = 3;
    localparam int MOD   = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             dir;
    logic [1:0]       seq_sel;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;

    typedef struct {
        string tag;
        int    cnt;
        int    wr;
    } exp_t;

    exp_t r_sb[$];
    int   r_errors = 0;
    int   r_checks = 0;
    int   r_m_count;
    int   r_m_wrapped;

    odd_even_updown_counter #(.WIDTH(WIDTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .seq_sel  (seq_sel),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrapped  (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        r_checks++;
        if (actual !== expected) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int model_tc(input int c, input logic d, input logic [1:0] s);
        int term;
        if (d) term = (s == 2'b10) ? MOD - 2 : MOD - 1;
        else   term = (s == 2'b01) ? 1 : 0;
        return (c == term) ? 1 : 0;
    endfunction

    function automatic int force_par(input int v, input logic [1:0] s);
        if (s == 2'b01) return v | 1;
        if (s == 2'b10) return v & ~1;
        return v;
    endfunction

    // Drive one cycle of controls, advance the model, queue expectation, then compare
    task automatic step(input string tag, input logic ld, input int lv, input logic e,
                        input logic d, input logic [1:0] s, input logic sat);
        int   stp;
        int   nxt;
        exp_t ex;
        load = ld; load_val = lv[WIDTH-1:0]; en = e; dir = d; seq_sel = s; sat_mode = sat;
        if (ld) begin
            r_m_count   = force_par(lv, s);
            r_m_wrapped = 0;
        end else if (e) begin
            if (model_tc(r_m_count, d, s) == 1 && sat) begin
                r_m_wrapped = 0;
            end else begin
                stp = (s == 2'b01 || s == 2'b10) ? 2 : 1;
                nxt = d ? force_par(r_m_count, s) + stp : force_par(r_m_count, s) - stp + MOD;
                r_m_wrapped = model_tc(r_m_count, d, s);
                r_m_count   = nxt % MOD;
            end
        end else begin
            r_m_wrapped = 0;
        end
        ex.tag = tag; ex.cnt = r_m_count; ex.wr = r_m_wrapped;
        r_sb.push_back(ex);
        @(posedge clk);
        #1;
        if (r_sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            ex = r_sb.pop_front();
            check({ex.tag, "_count"}, int'(count), ex.cnt);
            check({ex.tag, "_wrapped"}, int'(wrapped), ex.wr);
            check({ex.tag, "_tc"}, int'(tc), model_tc(r_m_count, d, s));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; dir = 1'b1; seq_sel = 2'b01; sat_mode = 1'b0;
        load = 1'b0; load_val = '0;
        r_m_count = 7; r_m_wrapped = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", int'(count), 7);
        check("reset_wrapped", int'(wrapped), 0);
        check("reset_tc_up_odd", int'(tc), 1);

        // Odd down from reset: 5, 3, 1, then wrap back to 7
        dir = 1'b0;
        #1;
        check("reset_tc_down_odd", int'(tc), 0);
        rst = 1'b0;
        step("odd_dn1", 0, 0, 1, 0, 2'b01, 0);
        check("odd_dn1_const", int'(count), 5);
        step("odd_dn2", 0, 0, 1, 0, 2'b01, 0);
        step("odd_dn3", 0, 0, 1, 0, 2'b01, 0);
        check("odd_at1_tc", int'(tc), 1);
        step("odd_wrap", 0, 0, 1, 0, 2'b01, 0);
        check("odd_wrap_const", int'(wrapped), 1);
        step("odd_post", 0, 0, 1, 0, 2'b01, 0);

        // Even up with saturate
        step("even_ld", 1, 5, 1, 1, 2'b10, 1);
        check("even_ld_const", int'(count), 4);
        step("even_up", 0, 0, 1, 1, 2'b10, 1);
        step("even_sat1", 0, 0, 1, 1, 2'b10, 1);
        step("even_sat2", 0, 0, 1, 1, 2'b10, 1);
        check("even_sat_const", int'(count), 6);

        // Load priority over en with odd parity correction
        step("ld_prio", 1, 2, 1, 0, 2'b01, 0);
        check("ld_prio_const", int'(count), 3);

        // Mode switch: all mode at 6, then odd down
        step("ms_ld", 1, 6, 0, 0, 2'b00, 0);
        step("ms_odd1", 0, 0, 1, 0, 2'b01, 0);
        check("ms_odd1_const", int'(count), 5);
        step("ms_odd2", 0, 0, 1, 0, 2'b01, 0);

        // Async reset between edges at count 3
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 7);
        check("async_rst_wrapped", int'(wrapped), 0);
        @(negedge clk);
        rst = 1'b0;
        r_m_count = 7; r_m_wrapped = 0;

        // All mode up wrap, then hold with en low
        step("all_up_wrap", 0, 0, 1, 1, 2'b00, 0);
        check("all_up_wrap_const", int'(count), 0);
        step("all_hold", 0, 0, 0, 1, 2'b00, 0);
        step("all_11_dn", 0, 0, 1, 0, 2'b11, 0);

        // Randomised controls tracked by the model
        for (int i = 0; i < 60; i++) begin
            step("rand", ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)));
        end

        check("sb_drained", r_sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/odd_even_updown_counter.md
# odd_even_updown_counter

Parametrised synchronous up/down counter with selectable sequence (all, odd-only, even-only), synchronous parity-corrected load, enable, and wrap or saturate end behaviour. It generalises the team's fixed 3-bit odd down counter into a single configurable counter block. It produces terminal-count and wrap indications for downstream sequencing logic. All state changes on the single clock; no ripple clocking.

## Interface
- WIDTH, 3, counter width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; one step per clk edge while high
- dir  input  1  0 = down, 1 = up
- seq_sel  input  2  00 = all values, 01 = odd only, 10 = even only, 11 = treated as 00
- sat_mode  input  1  0 = wrap at end of sequence, 1 = hold at terminal value
- load  input  1  synchronous load; priority over en
- load_val  input  WIDTH  value to load, parity-corrected per seq_sel
- count  output  WIDTH  current count (registered)
- tc  output  1  count equals terminal value for current dir/seq_sel (combinational decode of registered count)
- wrapped  output  1  registered one-cycle pulse after a wrap step

## Operation
- Step size: 1 for all mode, 2 for odd/even modes.
- Base value: count with LSB forced to the mode parity (odd: 1, even: 0, all: unchanged).
- Next value on an enabled step = base ± step, modulo 2^WIDTH. Modular arithmetic yields the sequence wrap directly:
  - odd down 1 → all-ones
  - even down 0 → 2^WIDTH−2
  - odd up all-ones → 1
  - even up 2^WIDTH−2 → 0
- Terminal values:
  - down: all → 0, odd → 1, even → 0
  - up: all → 2^WIDTH−1, odd → 2^WIDTH−1, even → 2^WIDTH−2
- Wrap step: an enabled step taken while tc = 1 and sat_mode = 0. count takes the modular next value; wrapped = 1 on the following cycle only.
- Saturate: when tc = 1, sat_mode = 1 and en = 1, count holds. wrapped stays 0.
- Load: count ← load_val with LSB forced to mode parity (all mode: unchanged). wrapped ← 0. en is ignored that cycle.
- en = 0 and load = 0: count holds, wrapped ← 0.
- Mode or direction change mid-run: the next enabled step uses the new controls. Example, WIDTH=3: count = 6, switch to odd down → base 7 → next 5. tc re-evaluates immediately against the new terminal.

## Timing
- Reset: count = 2^WIDTH−1 (all ones), wrapped = 0. tc is the decode of that count, e.g. 1 if dir = 1 and seq_sel = 01.
- Reset asserts asynchronously. Deassertion is sampled at the next clk edge; the first step occurs on the first rising edge with rst low and en or load high.
- Latency: one clk edge from en/load to the new count.
- wrapped is high exactly one cycle, aligned with the post-wrap count.
- tc has zero-cycle response to changes on count, dir and seq_sel.
- Reset mid-operation overrides load and en instantly; no partial update.

## Structure
- Shared package counter_pkg holds:
  - seq_sel encodings: SEQ_ALL, SEQ_ODD, SEQ_EVEN
  - direction constants DIR_DOWN, DIR_UP
- Sub-module counter_next_calc is purely combinational and is parametrised by WIDTH. It provides:
  - the parity-forced base
  - the stepped value
  - the terminal-value compare
- Top level holds the count/wrapped registers and the load/en/saturate priority mux.

## Test plan
All cases use WIDTH = 3.
- Reset, odd down: release reset with en = 1, seq_sel = 01, dir = 0.
  - count sequence 7, 5, 3, 1, 7.
  - tc high at 1.
  - wrapped pulses on the cycle count returns to 7.
- Even up with saturate: load 5, seq_sel = 10, dir = 1, sat_mode = 1.
  - load gives 4, then 6.
  - count holds at 6 with tc = 1 and wrapped = 0 thereafter.
- Load priority and parity: load = 1, en = 1, load_val = 2, seq_sel = 01.
  - count = 3 next cycle, not 1 or 5.
- Mode switch mid-run: all-mode down at count 6, then switch to odd.
  - next count 5, then 3.
- Async reset mid-count: assert rst between edges at count 3.
  - count = 7 and wrapped = 0 immediately, before the next clk edge.
- All mode up wrap: from 7 with en = 1.
  - count 0, wrapped = 1 for one cycle.
  - en = 0 then holds count and clears wrapped.
